// File: rtl/mvm_serial_engine_if.sv
// Load/start/done handshake and operand/result buses of the serial matrix-vector engine.
// The host drives through master; the engine responds through slave.
interface mvm_serial_engine_if #(
   parameter int B = 8
);
   logic                  loadMatrix;
   logic                  loadVector;
   logic                  start;
   logic                  done;
   logic signed [B-1:0]   data_in;
   logic signed [2*B-1:0] data_out;

   modport master (
      output loadMatrix, loadVector, start, data_in,
      input  done, data_out
   );

   modport slave (
      input  loadMatrix, loadVector, start, data_in,
      output done, data_out
   );
endinterface

// File: rtl/mvm_serial_engine.sv
// Serial matrix-vector multiply engine: loads a KxK matrix and K-vector word by word,
// computes y = M*v through a single MAC, then pulses done and streams y on data_out.
module mvm_serial_engine #(
   parameter int K = 32,
   parameter int B = 8
) (
   input logic              clk,
   input logic              reset,
   mvm_serial_engine_if.slave bus
);
   localparam int CW = $clog2(K*K);
   localparam int RW = $clog2(K);

   typedef enum logic [2:0] {
      IDLE, LOAD_M, LOAD_V, ENTRY, COMPUTE, WRITEBACK, DONE, OUTPUT
   } state_t;

   state_t state, nextState;

   logic [CW-1:0]         wordCnt;
   logic [RW-1:0]         rowCnt;
   logic [RW-1:0]         colCnt;
   logic signed [2*B-1:0] acc;
   logic signed [2*B-1:0] product;
   logic                  wordLast;
   logic                  colLast;
   logic                  rowLast;

   logic signed [B-1:0]   matrix [K*K];
   logic signed [B-1:0]   vector [K];
   logic signed [2*B-1:0] result [K];

   assign wordLast = (wordCnt == CW'(K*K-1));
   assign colLast  = (colCnt == RW'(K-1));
   assign rowLast  = (rowCnt == RW'(K-1));
   assign product  = matrix[wordCnt] * vector[colCnt];

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (bus.loadMatrix) begin
               nextState = LOAD_M;
            end else if (bus.loadVector) begin
               nextState = LOAD_V;
            end else if (bus.start) begin
               nextState = ENTRY;
            end
         end
         LOAD_M:    if (wordLast) nextState = IDLE;
         LOAD_V:    if (colLast) nextState = IDLE;
         ENTRY:     nextState = COMPUTE;
         COMPUTE:   if (wordLast) nextState = WRITEBACK;
         WRITEBACK: nextState = DONE;
         DONE:      nextState = OUTPUT;
         OUTPUT:    if (rowLast) nextState = IDLE;
         default:   nextState = IDLE;
      endcase
   end

   always_comb begin
      bus.done     = 1'b0;
      bus.data_out = '0;
      if (state == DONE) begin
         bus.done = 1'b1;
      end
      if (state == OUTPUT) begin
         bus.data_out = result[rowCnt];
      end
   end

   // Matrix loads and the MAC walk the same row-major word/row/column counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         wordCnt <= '0;
         rowCnt  <= '0;
         colCnt  <= '0;
         acc     <= '0;
      end else begin
         case (state)
            LOAD_M, COMPUTE: begin
               wordCnt <= wordLast ? '0 : wordCnt + 1'b1;
               colCnt  <= colLast ? '0 : colCnt + 1'b1;
               if (colLast) begin
                  rowCnt <= rowLast ? '0 : rowCnt + 1'b1;
               end
               if (state == COMPUTE) begin
                  acc <= ((colCnt == '0) ? '0 : acc) + product;
               end
            end
            LOAD_V: begin
               colCnt <= colLast ? '0 : colCnt + 1'b1;
            end
            OUTPUT: begin
               rowCnt <= rowLast ? '0 : rowCnt + 1'b1;
            end
            default: begin
               wordCnt <= '0;
               rowCnt  <= '0;
               colCnt  <= '0;
            end
         endcase
      end
   end

   // Operand and result storage is never cleared; a finished row is retired when the next row begins.
   always_ff @(posedge clk) begin
      if (!reset) begin
         case (state)
            LOAD_M: matrix[wordCnt] <= bus.data_in;
            LOAD_V: vector[colCnt] <= bus.data_in;
            COMPUTE: begin
               if (colCnt == '0 && rowCnt != '0) begin
                  result[rowCnt - 1'b1] <= acc;
               end
            end
            WRITEBACK: result[K-1] <= acc;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mvm_serial_engine.sv
// Scoreboard bench for mvm_serial_engine: stimulus queues the expected done cycle and
// result words; a negedge monitor pops and compares them whenever the engine responds.
module tb_mvm_serial_engine;
   localparam int K = 32;
   localparam int B = 8;

   typedef logic signed [B-1:0]   word_t;
   typedef logic signed [2*B-1:0] res_t;

   logic clk = 1'b0;
   logic reset;

   mvm_serial_engine_if #(.B(B)) bus ();

   mvm_serial_engine #(.K(K), .B(B)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int    cycleCount = 0;
   int    testsRun = 0;
   int    failCount = 0;
   int    outRemaining = 0;
   bit    monitorOn = 1'b0;
   res_t  expQ[$];
   int    expDoneQ[$];
   word_t burst[$];
   res_t  expWords[$];

   always @(posedge clk) cycleCount <= cycleCount + 1;

   task automatic checkOutput(input string name, input logic signed [31:0] actual,
                              input logic signed [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCount);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: outside a result window data_out must be 0; done opens a K-word window.
   always @(negedge clk) begin
      if (monitorOn) begin
         if (reset) begin
            outRemaining = 0;
         end else begin
            if (outRemaining > 0) begin
               if (expQ.size() == 0) begin
                  testsRun++;
                  failCount++;
                  $display("[TB] FAIL dataOut: got %0d, expected no word (cycle %0d)", bus.data_out, cycleCount);
               end else begin
                  checkOutput("dataOut", bus.data_out, expQ.pop_front());
               end
               outRemaining--;
            end else begin
               checkOutput("idleZero", bus.data_out, 0);
            end
            if (bus.done === 1'b1) begin
               if (expDoneQ.size() == 0) begin
                  testsRun++;
                  failCount++;
                  $display("[TB] FAIL unexpectedDone: got done=1, expected 0 (cycle %0d)", cycleCount);
               end else begin
                  checkOutput("doneCycle", cycleCount, expDoneQ.pop_front());
               end
               outRemaining = K;
            end
         end
      end
   end

   task automatic fillMatrix(input int mode, input word_t val);
      burst.delete();
      for (int i = 0; i < K*K; i++) begin
         if (mode == 1) burst.push_back(((i / K) == (i % K)) ? word_t'(1) : word_t'(0));
         else burst.push_back(val);
      end
   endtask

   task automatic fillVector(input int mode, input word_t val);
      burst.delete();
      for (int i = 0; i < K; i++) begin
         if (mode == 1) burst.push_back(word_t'(i));
         else if (mode == 2) burst.push_back(word_t'(i - 16));
         else burst.push_back(val);
      end
   endtask

   task automatic setExpected(input int mode, input res_t val);
      expWords.delete();
      for (int i = 0; i < K; i++) begin
         if (mode == 1) expWords.push_back(res_t'(i));
         else if (mode == 2) expWords.push_back(res_t'(i - 16));
         else expWords.push_back(val);
      end
   endtask

   task automatic sendLoad(input bit isMatrix, input bit both, input int startAt);
      tick();
      bus.loadMatrix = isMatrix || both;
      bus.loadVector = !isMatrix || both;
      tick();
      bus.loadMatrix = 1'b0;
      bus.loadVector = 1'b0;
      for (int i = 0; i < burst.size(); i++) begin
         bus.data_in = burst[i];
         bus.start   = (i == startAt);
         tick();
      end
      bus.start   = 1'b0;
      bus.data_in = word_t'(8'h5A);
      tick();
      tick();
   endtask

   task automatic applyStimulus();
      tick();
      bus.start = 1'b1;
      expDoneQ.push_back(cycleCount + 1 + K*K + 2);
      foreach (expWords[i]) expQ.push_back(expWords[i]);
      tick();
      bus.start = 1'b0;
   endtask

   task automatic waitIdle(input int limit);
      int n = 0;
      while (n < limit && !(outRemaining == 0 && expQ.size() == 0 && expDoneQ.size() == 0)) begin
         @(negedge clk);
         n++;
      end
      if (!(outRemaining == 0 && expQ.size() == 0 && expDoneQ.size() == 0)) begin
         testsRun++;
         failCount++;
         $display("[TB] FAIL waitIdle: got %0d words and %0d done pending, expected 0 after %0d cycles",
                  expQ.size(), expDoneQ.size(), limit);
         expQ.delete();
         expDoneQ.delete();
      end
   endtask

   initial begin
      int n;
      reset          = 1'b1;
      bus.loadMatrix = 1'b0;
      bus.loadVector = 1'b0;
      bus.start      = 1'b0;
      bus.data_in    = '0;
      tick();
      tick();
      @(negedge clk);
      checkOutput("resetDone", bus.done, 0);
      checkOutput("resetData", bus.data_out, 0);
      tick();
      reset     = 1'b0;
      monitorOn = 1'b1;

      // All-ones matrix and vector: every row sums to K.
      fillMatrix(0, word_t'(1));
      sendLoad(1'b1, 1'b0, -1);
      fillVector(0, word_t'(1));
      sendLoad(1'b0, 1'b0, -1);
      setExpected(0, res_t'(32));
      applyStimulus();
      waitIdle(2000);

      // Vector first, then identity matrix: y[i] = i.
      fillVector(1, '0);
      sendLoad(1'b0, 1'b0, -1);
      fillMatrix(1, '0);
      sendLoad(1'b1, 1'b0, -1);
      setExpected(1, '0);
      applyStimulus();
      waitIdle(2000);

      // Reuse identity matrix with a new vector; stray starts in LOAD_V and OUTPUT are ignored.
      fillVector(0, word_t'(2));
      sendLoad(1'b0, 1'b0, 10);
      setExpected(0, res_t'(2));
      applyStimulus();
      n = 0;
      while (outRemaining == 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      tick();
      tick();
      tick();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      waitIdle(2000);

      // Accumulator wrap: 32*127*127 wraps to -8160, 32*(-128)*(-128) wraps to 0.
      fillMatrix(0, word_t'(127));
      sendLoad(1'b1, 1'b0, -1);
      fillVector(0, word_t'(127));
      sendLoad(1'b0, 1'b0, -1);
      setExpected(0, res_t'(-8160));
      applyStimulus();
      waitIdle(2000);
      fillMatrix(0, word_t'(-128));
      sendLoad(1'b1, 1'b0, -1);
      fillVector(0, word_t'(-128));
      sendLoad(1'b0, 1'b0, -1);
      setExpected(0, res_t'(0));
      applyStimulus();
      waitIdle(2000);

      // Reset mid-compute aborts; a fresh start recomputes the stored identity * (i-16).
      fillMatrix(1, '0);
      sendLoad(1'b1, 1'b0, -1);
      fillVector(2, '0);
      sendLoad(1'b0, 1'b0, -1);
      setExpected(2, '0);
      applyStimulus();
      repeat (500) tick();
      reset = 1'b1;
      expQ.delete();
      expDoneQ.delete();
      tick();
      reset = 1'b0;
      @(negedge clk);
      checkOutput("abortDone", bus.done, 0);
      checkOutput("abortData", bus.data_out, 0);
      repeat (1100) tick();
      applyStimulus();
      waitIdle(2000);

      // Both load pulses together load the matrix: all-2 matrix * (i-16) gives 2*(-16) = -32.
      fillMatrix(0, word_t'(2));
      sendLoad(1'b1, 1'b1, -1);
      setExpected(0, res_t'(-32));
      applyStimulus();
      waitIdle(2000);

      repeat (4) tick();
      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end
endmodule
